// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
// Frame states, device command bytes and the parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one PS/2 line.
// A new level is accepted only after FILT identical samples.
module ps2_line_filter #(
  parameter int FILT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level
);

  localparam int CW = $clog2(FILT + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Idle PS/2 lines are high, so everything resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      s1 <= line_in;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter.
// Inhibits the bus, sends start/8 data/parity/stop, checks the device ack.
module ps2_host_tx #(
  parameter int CLKFREQ    = 28000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_MS = 15,
  parameter int FILT       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       tx_active,
  output logic       done,
  output logic       error
);

  import ps2_host_tx_pkg::*;

  localparam int INH_CYC = CLKFREQ * INHIBIT_US / 1000;
  localparam int TO_CYC  = CLKFREQ * TIMEOUT_MS;
  localparam int CMAX    = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int CW      = $clog2(CMAX) + 1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [9:0]    sh, sh_n;
  logic          drv, drv_n;
  logic          clk_f, dat_f, clk_q;
  logic          fall;

  ps2_line_filter #(.FILT(FILT)) u_clk_filt (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2clk_in),
    .level   (clk_f)
  );

  ps2_line_filter #(.FILT(FILT)) u_dat_filt (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2data_in),
    .level   (dat_f)
  );

  assign fall = clk_q & ~clk_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      sh     <= '0;
      drv    <= 1'b0;
      clk_q  <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      sh     <= sh_n;
      drv    <= drv_n;
      clk_q  <= clk_f;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    sh_n     = sh;
    drv_n    = drv;
    unique case (state)
      S_IDLE: begin
        cnt_n    = '0;
        bitcnt_n = '0;
        drv_n    = 1'b0;
        if (tx_start) begin
          state_n = S_INHIBIT;
          sh_n    = {1'b1, odd_parity(tx_data), tx_data};
        end
      end
      S_INHIBIT: begin
        if (cnt == CW'(INH_CYC - 1)) begin
          state_n = S_REQ;
          cnt_n   = '0;
          drv_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_REQ: state_n = S_SHIFT;
      S_SHIFT: begin
        // Stop bit sits in sh[9] as 1, so it shifts out as a release.
        if (fall) begin
          drv_n    = ~sh[0];
          sh_n     = {1'b0, sh[9:1]};
          bitcnt_n = bitcnt + 4'd1;
          if (bitcnt == 4'd9) state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) state_n = dat_f ? S_ERR : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (clk_f && dat_f) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (state inside {S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE}) begin
      cnt_n = cnt + 1'b1;
      if (cnt == CW'(TO_CYC - 1)) state_n = S_ERR;
    end
    if (state_n == S_ERR) drv_n = 1'b0;
  end

  assign ps2clk_oe  = (state == S_INHIBIT);
  assign ps2data_oe = drv;
  assign busy       = (state != S_IDLE);
  assign tx_active  = busy;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out
// of the host and checks bits, ack/nack, timeout, glitches and reset.
module tb_ps2_host_tx;

  localparam int CLKFREQ    = 1000;
  localparam int INHIBIT_US = 120;
  localparam int TIMEOUT_MS = 15;
  localparam int FILT       = 8;
  localparam int INH        = CLKFREQ * INHIBIT_US / 1000;
  localparam int TO         = CLKFREQ * TIMEOUT_MS;
  localparam int H          = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2clk_in, ps2data_in;
  logic       ps2clk_oe, ps2data_oe;
  logic       busy, tx_active, done, error;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;

  assign ps2clk_in  = dev_clk & ~ps2clk_oe;
  assign ps2data_in = dev_data & ~ps2data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLKFREQ    (CLKFREQ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_MS (TIMEOUT_MS),
    .FILT       (FILT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2clk_in  (ps2clk_in),
    .ps2data_in (ps2data_in),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .busy       (busy),
    .tx_active  (tx_active),
    .done       (done),
    .error      (error)
  );

  always @(negedge clk) begin
    if (done) n_done++;
    if (error) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Bits as the device should see them: d0..d7, odd parity, stop.
  function automatic logic [9:0] model_bits(input logic [7:0] b);
    logic [9:0] r;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[i];
      ones += int'(b[i]);
    end
    r[8] = (ones % 2 == 0);
    r[9] = 1'b1;
    return r;
  endfunction

  task automatic start_tx(input logic [7:0] b);
    int n;
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("accept_clk_oe", ps2clk_oe, 1);
    chk("busy_set", {busy, tx_active}, 2'b11);
    n = 0;
    while (ps2clk_oe && n < INH + 50) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", n, INH);
    chk("req_lines", {ps2clk_oe, ps2data_oe}, 2'b01);
  endtask

  task automatic run_dev(input logic [7:0] b, input bit ack,
                         input bit glitch, input int rst_at,
                         input bit poke);
    logic [9:0] got, exp;
    logic       exp_d;
    int d0, e0, k;
    bit seen;
    got = '0;
    exp = model_bits(b);
    d0  = n_done;
    e0  = n_err;
    for (int i = 0; i < 11; i++) begin
      if (glitch) begin
        repeat (H / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H / 2 - 5) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (i == 10 && ack) dev_data = 1'b0;
      if (i == rst_at) begin
        repeat (15) @(negedge clk);
        exp_d = exp[i] ? 1'b0 : 1'b1;
        chk("pre_rst_data", ps2data_oe, exp_d);
        #2 rst = 1'b1;
        #1;
        chk("rst_oe", {ps2clk_oe, ps2data_oe}, 0);
        chk("rst_busy", {busy, tx_active}, 0);
        @(negedge clk);
        rst      = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_no_done", n_done - d0, 0);
        chk("rst_no_err", n_err - e0, 0);
        return;
      end
      if (poke && i == 2) begin
        @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (H - 2) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      if (i < 10) got[i] = ps2data_in;
      dev_clk = 1'b1;
      if (i == 10) dev_data = 1'b1;
    end
    k = 0;
    while (n_done == d0 && n_err == e0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    chk("bits", got, exp);
    chk("done_cnt", n_done - d0, ack);
    chk("err_cnt", n_err - e0, !ack);
    chk("idle_lines", {busy, ps2clk_oe, ps2data_oe}, 0);
    if (poke) begin
      seen = 1'b0;
      for (int j = 0; j < 200; j++) begin
        @(negedge clk);
        if (ps2clk_oe || busy) seen = 1'b1;
      end
      chk("no_second_frame", seen, 0);
    end
  endtask

  initial begin
    int c;
    logic [7:0] rb;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {ps2clk_oe, ps2data_oe, busy, tx_active, done, error}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    start_tx(8'hED);
    run_dev(8'hED, 1'b1, 1'b0, -1, 1'b0);

    start_tx(8'hF4);
    run_dev(8'hF4, 1'b0, 1'b0, -1, 1'b0);

    start_tx(8'h5A);
    c = 0;
    while (!error && c < TO + 100) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_cycles", c, TO);
    @(negedge clk);
    chk("timeout_idle", {busy, ps2clk_oe, ps2data_oe}, 0);

    rb = 8'($urandom);
    start_tx(rb);
    run_dev(rb, 1'b1, 1'b1, -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      rb = 8'($urandom);
      start_tx(rb);
      run_dev(rb, 1'b1, 1'b0, -1, 1'b0);
    end

    start_tx(8'h0F);
    run_dev(8'h0F, 1'b1, 1'b0, 4, 1'b0);
    start_tx(8'hFF);
    run_dev(8'hFF, 1'b1, 1'b0, -1, 1'b0);

    start_tx(8'h3C);
    run_dev(8'h3C, 1'b1, 1'b0, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
